// File: rtl/lcd_ctrl_gen_pkg.sv
// Shared types for the parametrised LCD window controller: command codes,
// FSM states, display modes and a width helper.
package lcd_ctrl_gen_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD     = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_FIT = 3'd2,
    CMD_RIGHT    = 3'd3,
    CMD_LEFT     = 3'd4,
    CMD_UP       = 3'd5,
    CMD_DOWN     = 3'd6,
    CMD_MIRROR   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef enum logic {
    FIT  = 1'b0,
    ZOOM = 1'b1
  } mode_e;

  // Bits needed to hold values 0..range-1, never less than one bit.
  function automatic int unsigned cw(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/lcd_win_addr.sv
// Combinational window address generator: maps window coordinate (r, c)
// to an image memory address for ZOOM or FIT sampling, with optional mirror.
module lcd_win_addr
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_X0 = 1,
  parameter int FIT_Y0 = 1,
  parameter int FIT_SX = 3,
  parameter int FIT_SY = 2,
  localparam int AW = cw(IMG_W * IMG_H),
  localparam int XW = cw(IMG_W - WIN + 1),
  localparam int YW = cw(IMG_H - WIN + 1),
  localparam int CW = cw(WIN)
) (
  input  mode_e         mode_i,
  input  logic          mirror_i,
  input  logic [XW-1:0] x0_i,
  input  logic [YW-1:0] y0_i,
  input  logic [CW-1:0] r_i,
  input  logic [CW-1:0] c_i,
  output logic [AW-1:0] addr_o
);

  logic [CW-1:0] c_eff;
  int unsigned   row;
  int unsigned   col;

  // Arithmetic is done at 32 bits so no intermediate term can overflow.
  always_comb begin
    c_eff = mirror_i ? (CW'(WIN - 1) - c_i) : c_i;
    if (mode_i == ZOOM) begin
      row = 32'(y0_i) + 32'(r_i);
      col = 32'(x0_i) + 32'(c_eff);
    end else begin
      row = FIT_Y0 + 32'(r_i) * FIT_SY;
      col = FIT_X0 + 32'(c_eff) * FIT_SX;
    end
    addr_o = AW'(row * IMG_W + col);
  end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// LCD window controller: serial image load into internal storage, then a
// WIN x WIN raster burst after every accepted command.
module lcd_ctrl_gen
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_X0 = 1,
  parameter int FIT_Y0 = 1,
  parameter int FIT_SX = 3,
  parameter int FIT_SY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy
);

  localparam int N     = IMG_W * IMG_H;
  localparam int AW    = cw(N);
  localparam int XW    = cw(IMG_W - WIN + 1);
  localparam int YW    = cw(IMG_H - WIN + 1);
  localparam int CW    = cw(WIN);
  localparam int X_MAX = IMG_W - WIN;
  localparam int Y_MAX = IMG_H - WIN;
  localparam int X_CTR = IMG_W / 2 - WIN / 2;
  localparam int Y_CTR = IMG_H / 2 - WIN / 2;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              mirror_q, mirror_d;
  logic [XW-1:0]     x0_q, x0_d;
  logic [YW-1:0]     y0_q, y0_d;
  logic [CW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [AW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              mem_we;
  logic              accept;
  logic [AW-1:0]     rd_addr;

  logic [DATA_W-1:0] mem_q [N];

  lcd_win_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN),
    .FIT_X0(FIT_X0),
    .FIT_Y0(FIT_Y0),
    .FIT_SX(FIT_SX),
    .FIT_SY(FIT_SY)
  ) u_addr (
    .mode_i  (mode_q),
    .mirror_i(mirror_q),
    .x0_i    (x0_q),
    .y0_i    (y0_q),
    .r_i     (r_q),
    .c_i     (c_q),
    .addr_o  (rd_addr)
  );

  assign accept = (state_q == IDLE) && cmd_valid && !busy_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    state_d   = state_q;
    mode_d    = mode_q;
    mirror_d  = mirror_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    r_d       = r_q;
    c_d       = c_q;
    ld_cnt_d  = ld_cnt_q;
    dataout_d = dataout_q;
    valid_d   = 1'b0;
    busy_d    = (state_q != IDLE);
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d   = 1'b1;
          r_d      = '0;
          c_d      = '0;
          ld_cnt_d = '0;
          state_d  = (cmd_e'(cmd) == CMD_LOAD) ? LOAD : OUT;
          case (cmd_e'(cmd))
            CMD_ZOOM_IN: begin
              if (mode_q == FIT) begin
                mode_d = ZOOM;
                x0_d   = XW'(X_CTR);
                y0_d   = YW'(Y_CTR);
              end
            end
            CMD_ZOOM_FIT: mode_d = FIT;
            CMD_RIGHT: if (mode_q == ZOOM && x0_q != XW'(X_MAX)) x0_d = x0_q + 1'b1;
            CMD_LEFT:  if (mode_q == ZOOM && x0_q != '0)         x0_d = x0_q - 1'b1;
            CMD_DOWN:  if (mode_q == ZOOM && y0_q != YW'(Y_MAX)) y0_d = y0_q + 1'b1;
            CMD_UP:    if (mode_q == ZOOM && y0_q != '0)         y0_d = y0_q - 1'b1;
            CMD_MIRROR: mirror_d = !mirror_q;
            default: ;
          endcase
        end
      end
      LOAD: begin
        mem_we = 1'b1;
        if (ld_cnt_q == AW'(N - 1)) begin
          state_d  = OUT;
          mode_d   = FIT;
          mirror_d = 1'b0;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      OUT: begin
        valid_d   = 1'b1;
        dataout_d = mem_q[rd_addr];
        if (c_q == CW'(WIN - 1)) begin
          c_d = '0;
          if (r_q == CW'(WIN - 1)) state_d = IDLE;
          else                     r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= FIT;
      mirror_q  <= 1'b0;
      x0_q      <= XW'(X_CTR);
      y0_q      <= YW'(Y_CTR);
      r_q       <= '0;
      c_q       <= '0;
      ld_cnt_q  <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mirror_q  <= mirror_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      r_q       <= r_d;
      c_q       <= c_d;
      ld_cnt_q  <= ld_cnt_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: the image memory has no reset; contents survive a reset by design.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[ld_cnt_q] <= datain;
  end

  assign dataout      = dataout_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen with the default 12x9 image and 4x4 window;
// pixel (y,x) is loaded with value y*12+x so every output equals its address.
module tb_lcd_ctrl_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] seen [16];

  always #5 clk = ~clk;

  lcd_ctrl_gen dut (
    .clk         (clk),
    .reset       (reset),
    .datain      (datain),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .dataout     (dataout),
    .output_valid(output_valid),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected pixel k of a burst for a 12-wide image holding value y*12+x.
  function automatic logic [7:0] exp_pix(input bit zm, input bit mir,
                                         input int x0, input int y0, input int k);
    int r, c, cp;
    r  = k / 4;
    c  = k % 4;
    cp = mir ? 3 - c : c;
    if (zm) return 8'((y0 + r) * 12 + x0 + cp);
    else    return 8'((1 + 2 * r) * 12 + 1 + 3 * cp);
  endfunction

  task automatic send_cmd(input string tag, input logic [2:0] c);
    @(negedge clk);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_busy_acc"}, 32'(busy), 1);
    check({tag, "_novalid_acc"}, 32'(output_valid), 0);
  endtask

  task automatic burst(input string tag, input bit zm, input bit mir,
                       input int x0, input int y0, input int pulse_at, input int reset_at);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check({tag, "_valid"}, 32'(output_valid), 1);
      check({tag, "_data"}, 32'(dataout), 32'(exp_pix(zm, mir, x0, y0, k)));
      seen[k] = dataout;
      if (k == pulse_at) begin
        cmd       = 3'd7;
        cmd_valid = 1'b1;
      end
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_rst_valid"}, 32'(output_valid), 0);
        check({tag, "_rst_busy"}, 32'(busy), 0);
        check({tag, "_rst_data"}, 32'(dataout), 0);
        return;
      end
    end
    @(negedge clk);
    check({tag, "_end_valid"}, 32'(output_valid), 0);
    check({tag, "_end_busy"}, 32'(busy), 0);
  endtask

  task automatic load_image(input string tag);
    send_cmd(tag, 3'd0);
    for (int i = 0; i < 108; i++) begin
      datain = 8'(i);
      @(negedge clk);
    end
    check({tag, "_load_busy"}, 32'(busy), 1);
    check({tag, "_load_novalid"}, 32'(output_valid), 0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd       = 3'd0;
    cmd_valid = 1'b0;
    datain    = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", 32'(output_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(dataout), 0);

    // 1: load then fit burst
    load_image("load1");
    burst("fit1", 1'b0, 1'b0, 0, 0, -1, -1);
    check("fit1_first", 32'(seen[0]), 13);
    check("fit1_last", 32'(seen[15]), 94);

    // 2: zoom in at centre, twice
    send_cmd("zin1", 3'd1);
    burst("zin1", 1'b1, 1'b0, 4, 2, -1, -1);
    check("zin1_first", 32'(seen[0]), 28);
    check("zin1_last", 32'(seen[15]), 67);
    send_cmd("zin2", 3'd1);
    burst("zin2", 1'b1, 1'b0, 4, 2, -1, -1);

    // 3: right x5 saturates at 8, up x3 saturates at 0
    for (int i = 1; i <= 5; i++) begin
      send_cmd("right", 3'd3);
      burst("right", 1'b1, 1'b0, (4 + i > 8) ? 8 : 4 + i, 2, -1, -1);
    end
    check("right_sat_first", 32'(seen[0]), 32);
    for (int i = 1; i <= 3; i++) begin
      send_cmd("up", 3'd5);
      burst("up", 1'b1, 1'b0, 8, (2 - i < 0) ? 0 : 2 - i, -1, -1);
    end
    check("up_sat_first", 32'(seen[0]), 8);
    send_cmd("left", 3'd4);
    burst("left", 1'b1, 1'b0, 7, 0, -1, -1);
    send_cmd("down", 3'd6);
    burst("down", 1'b1, 1'b0, 7, 1, -1, -1);
    send_cmd("right2", 3'd3);
    burst("right2", 1'b1, 1'b0, 8, 1, -1, -1);
    send_cmd("up2", 3'd5);
    burst("up2", 1'b1, 1'b0, 8, 0, -1, -1);

    // 4: mirror in zoom, then fit keeps mirror, load clears it
    send_cmd("mir", 3'd7);
    burst("mir", 1'b1, 1'b1, 8, 0, -1, -1);
    check("mir_first", 32'(seen[0]), 11);
    send_cmd("fitm", 3'd2);
    burst("fitm", 1'b0, 1'b1, 0, 0, -1, -1);
    check("fitm_first", 32'(seen[0]), 22);
    load_image("load2");
    burst("fit2", 1'b0, 1'b0, 0, 0, -1, -1);

    // 5: move in fit mode is a no-op; mid-burst strobe is ignored
    send_cmd("fitr", 3'd3);
    burst("fitr", 1'b0, 1'b0, 0, 0, 7, -1);
    @(negedge clk);
    check("no_extra_valid", 32'(output_valid), 0);
    check("no_extra_busy", 32'(busy), 0);
    send_cmd("mir2", 3'd7);
    burst("mir2", 1'b0, 1'b1, 0, 0, -1, -1);
    check("mir2_first", 32'(seen[0]), 22);

    // 6: reset mid-burst, then zoom from centre without mirror
    send_cmd("zrst", 3'd1);
    burst("zrst", 1'b1, 1'b1, 4, 2, -1, 4);
    send_cmd("zpost", 3'd1);
    burst("zpost", 1'b1, 1'b0, 4, 2, -1, -1);
    check("zpost_first", 32'(seen[0]), 28);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
